nibble_serial_adder_seq: RTL and testbench

// - Multi-cycle WIDTH-bit adder built around one ripple_carry_adder (4-bit) instance, time-multiplexed.
// - Sits directly around the 4-bit adder: drives its A/B/Cin one nibble per cycle, LSB nibble first.
// - Consumes its Sum/Cout, registers the carry between nibbles and assembles the full-width result.
// - Valid/ready handshake on both operand input and result output.
//

---
 rtl/nibble_serial_adder_seq.sv | 127 ++++++++++++
 tb/tb_nibble_serial_adder_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_seq.sv
// Multi-cycle WIDTH-bit adder that time-multiplexes one 4-bit ripple-carry adder, LSB nibble first.
// Optional signed-overflow output `ovf` is enabled by defining NSADD_OVERFLOW_EN.

module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[4];

endmodule

module nibble_serial_adder_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef NSADD_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IW-1:0]    idx;
  logic [3:0]       nib_a, nib_b, nib_sum;
  logic             nib_cout;
  logic             accept, last, release_res;

  assign accept      = (state == IDLE) && start_valid;
  assign last        = (state == RUN) && (idx == IW'(NIB - 1));
  assign release_res = (state == DONE) && result_ready;

  // The adder only ever sees the latched operands, so input changes after accept are harmless.
  assign nib_a = a_q[{idx, 2'b00} +: 4];
  assign nib_b = b_q[{idx, 2'b00} +: 4];

  ripple_carry_adder u_rca (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:    if (release_res) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ready  = (state == IDLE);
    result_valid = (state == DONE);
    busy         = (state != IDLE);
  end

  // idx parks on the top nibble after the final pass rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= op_b;
      carry_q <= cin;
      idx     <= '0;
    end else if (state == RUN) begin
      sum[{idx, 2'b00} +: 4] <= nib_sum;
      carry_q                <= nib_cout;
      if (last) cout <= nib_cout;
      else      idx  <= idx + 1'b1;
    end
  end

`ifdef NSADD_OVERFLOW_EN
  // Signed overflow: operands agree in sign but the top result bit does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ovf <= 1'b0;
    else if (last)        ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[3] != a_q[WIDTH-1]);
    else if (release_res) ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// Self-checking bench for nibble_serial_adder_seq: directed vectors plus randomized traffic
// compared every cycle against a transaction-level model of the handshake and arithmetic.

module tb_nibble_serial_adder_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a, op_b;
  logic             cin;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef NSADD_OVERFLOW_EN
  logic             ovf;
  logic             last_ovf;
  logic             m_ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  bit model_on = 1'b0;
  int n_results = 0;

  // Model: phase 0 idle, 1 computing (m_left edges to go), 2 holding result.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [16:0] m_res   = '0;

  always #5 clk = ~clk;

  nibble_serial_adder_seq #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .cin          (cin),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .cout         (cout),
    .busy         (busy)
`ifdef NSADD_OVERFLOW_EN
    ,
    .ovf          (ovf)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pickOperand();
    case ($urandom_range(0, 4))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Transaction-level reference: full-width sum computed once at accept.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
    end else begin
      case (m_phase)
        0: if (start_valid) begin
          m_res   = {1'b0, op_a} + {1'b0, op_b} + 17'(cin);
`ifdef NSADD_OVERFLOW_EN
          m_ovf   = (op_a[15] == op_b[15]) && (m_res[15] != op_a[15]);
`endif
          m_left  = NIB;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (result_ready) begin
          m_phase = 0;
          n_results++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_on && rst_n) begin
      checkOutput("cmp_start_ready", 32'(start_ready), 32'(m_phase == 0));
      checkOutput("cmp_busy", 32'(busy), 32'(m_phase != 0));
      checkOutput("cmp_result_valid", 32'(result_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        checkOutput("cmp_sum", 32'(sum), 32'(m_res[15:0]));
        checkOutput("cmp_cout", 32'(cout), 32'(m_res[16]));
`ifdef NSADD_OVERFLOW_EN
        checkOutput("cmp_ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
    end
  end

  // Runs one operation from an idle negedge and returns to an idle negedge.
  task automatic applyStimulus(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic c, input int hold,
                               input logic [15:0] exp_sum, input logic exp_cout);
    int cyc;
    cyc = 0;
    while (!start_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({name, "_ready_before"}, 32'(start_ready), 32'd1);
    op_a         = a;
    op_b         = b;
    cin          = c;
    start_valid  = 1'b1;
    result_ready = (hold == 0);
    @(negedge clk);
    start_valid = 1'b0;
    checkOutput({name, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!result_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
      op_a = 16'($urandom);
      op_b = 16'($urandom);
      cin  = 1'($urandom);
    end
    checkOutput({name, "_latency"}, 32'(cyc), 32'(NIB));
    checkOutput({name, "_sum"}, 32'(sum), 32'(exp_sum));
    checkOutput({name, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef NSADD_OVERFLOW_EN
    last_ovf = ovf;
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start_valid = 1'b1;
      op_a        = 16'($urandom);
      op_b        = 16'($urandom);
      checkOutput({name, "_hold_valid"}, 32'(result_valid), 32'd1);
      checkOutput({name, "_hold_sum"}, 32'(sum), 32'(exp_sum));
      checkOutput({name, "_hold_start_ready"}, 32'(start_ready), 32'd0);
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    checkOutput({name, "_valid_dropped"}, 32'(result_valid), 32'd0);
    checkOutput({name, "_idle_again"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    op_a         = '0;
    op_b         = '0;
    cin          = 1'b0;

    // Reset held while inputs thrash.
    repeat (5) begin
      @(negedge clk);
      start_valid  = 1'($urandom);
      result_ready = 1'($urandom);
      op_a         = 16'($urandom);
      op_b         = 16'($urandom);
      cin          = 1'($urandom);
      #1;
      checkOutput("rst_start_ready", 32'(start_ready), 32'd1);
      checkOutput("rst_result_valid", 32'(result_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_sum", 32'(sum), 32'd0);
      checkOutput("rst_cout", 32'(cout), 32'd0);
    end
    @(negedge clk);
    start_valid  = 1'b0;
    result_ready = 1'b1;
    rst_n        = 1'b1;
    model_on     = 1'b1;
    @(negedge clk);

    applyStimulus("carry8", 16'h00FF, 16'h0001, 1'b0, 0, 16'h0100, 1'b0);
    applyStimulus("ripple_all", 16'hFFFF, 16'h0000, 1'b1, 0, 16'h0000, 1'b1);
    applyStimulus("backpressure", 16'h1234, 16'h1111, 1'b0, 5, 16'h2345, 1'b0);

    // Abort during the second RUN cycle.
    op_a        = 16'hAAAA;
    op_b        = 16'h5555;
    cin         = 1'b0;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_start_ready", 32'(start_ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_result_valid", 32'(result_valid), 32'd0);
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus("after_abort", 16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0);

    applyStimulus("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0);
`ifdef NSADD_OVERFLOW_EN
    checkOutput("pos_ovf_flag", 32'(last_ovf), 32'd1);
    checkOutput("ovf_cleared", 32'(ovf), 32'd0);
`endif
    applyStimulus("neg_ovf", 16'h8000, 16'h8000, 1'b0, 2, 16'h0000, 1'b1);
`ifdef NSADD_OVERFLOW_EN
    checkOutput("neg_ovf_flag", 32'(last_ovf), 32'd1);
`endif
    applyStimulus("mixed_no_ovf", 16'h0003, 16'hFFFF, 1'b0, 0, 16'h0002, 1'b1);
`ifdef NSADD_OVERFLOW_EN
    checkOutput("mixed_ovf_flag", 32'(last_ovf), 32'd0);
`endif

    // Randomized traffic with sporadic resets; the compare process does the checking.
    n_results = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst_n        = ($urandom_range(0, 249) != 0);
      start_valid  = ($urandom_range(0, 2) != 0);
      result_ready = ($urandom_range(0, 3) != 0);
      op_a         = pickOperand();
      op_b         = pickOperand();
      cin          = 1'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("random_results_seen", 32'(n_results >= 50), 32'd1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
